// File: rtl/stack_arith_unit.sv
// Signed multi-cycle arithmetic unit for the stack datapath: one-step ADD/SUB,
// shift-add MUL and restoring DIV on operand magnitudes, sign applied on completion.
module stack_arith_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] result,
    output logic             carryOut,
    output logic             div_zero,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);
    // Handshake: start is accepted only on an edge where busy = 0; done is a one-cycle
    // pulse with result valid, and start may already be high in that cycle for the next op.

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [2*WIDTH-1:0] HALF_WIDE = (2*WIDTH)'(1) << (WIDTH-1);
    localparam logic [WIDTH-1:0]   HALF      = WIDTH'(1) << (WIDTH-1);
    localparam logic [3:0]         LAST_ITER = 4'(WIDTH-1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t state, state_next;

    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q, b_mag, mplier, quot, rem;
    logic [2*WIDTH-1:0] acc, mcand;
    logic [3:0]         cnt;

    logic [WIDTH-1:0]   in1_mag, in2_mag, rem_diff, prod_s, quot_s;
    logic [WIDTH:0]     rem_shift, sum, dif;
    logic               rem_ge, neg, mul_ovf;

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_comb begin
        in1_mag   = in1[WIDTH-1] ? -in1 : in1;
        in2_mag   = in2[WIDTH-1] ? -in2 : in2;
        rem_shift = {rem, quot[WIDTH-1]};
        rem_ge    = (rem_shift >= {1'b0, b_mag});
        rem_diff  = rem_shift[WIDTH-1:0] - b_mag;
        sum       = {1'b0, a_q} + {1'b0, b_q};
        dif       = {1'b0, a_q} - {1'b0, b_q};
        neg       = a_q[WIDTH-1] ^ b_q[WIDTH-1];
        prod_s    = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        quot_s    = neg ? -quot : quot;
        // A negative product may reach -2^(WIDTH-1); a positive one stops one short.
        mul_ovf   = neg ? (acc > HALF_WIDE) : (acc >= HALF_WIDE);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (op == OP_MUL || (op != OP_ADD && op != OP_SUB && in2 != '0))
                        state_next = CALC;
                    else
                        state_next = FINISH;
                end
            end
            CALC:    if (cnt == LAST_ITER) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            b_mag    <= '0;
            mplier   <= '0;
            quot     <= '0;
            rem      <= '0;
            acc      <= '0;
            mcand    <= '0;
            cnt      <= '0;
            result   <= '0;
            carryOut <= 1'b0;
            div_zero <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        a_q    <= in1;
                        b_q    <= in2;
                        b_mag  <= in2_mag;
                        mplier <= in2_mag;
                        quot   <= in1_mag;
                        rem    <= '0;
                        acc    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, in1_mag};
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    cnt <= cnt + 4'd1;
                    if (op_q == OP_MUL) begin
                        if (mplier[0]) acc <= acc + mcand;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end else begin
                        // quot doubles as the dividend shift register; quotient bits fill from the right.
                        rem  <= rem_ge ? rem_diff : rem_shift[WIDTH-1:0];
                        quot <= {quot[WIDTH-2:0], rem_ge};
                    end
                end
                FINISH: begin
                    done     <= 1'b1;
                    cnt      <= '0;
                    carryOut <= 1'b0;
                    div_zero <= 1'b0;
                    case (op_q)
                        OP_ADD: begin
                            result   <= sum[WIDTH-1:0];
                            carryOut <= sum[WIDTH];
                        end
                        OP_SUB: begin
                            result   <= dif[WIDTH-1:0];
                            carryOut <= dif[WIDTH];
                        end
                        OP_MUL: begin
                            result   <= prod_s;
                            carryOut <= mul_ovf;
                        end
                        default: begin
                            if (b_q == '0) begin
                                result   <= '0;
                                div_zero <= 1'b1;
                            end else begin
                                result   <= quot_s;
                                carryOut <= !neg && (quot == HALF);
                            end
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_arith_unit.sv
// Self-checking bench for stack_arith_unit: directed feature tasks plus randomized
// operations scored against an integer-arithmetic reference model.
module tb_stack_arith_unit;
    logic       clk = 1'b0;
    logic       reset, start;
    logic [1:0] op;
    logic [7:0] in1, in2, result;
    logic       carryOut, div_zero, busy, done;
    logic [1:0] state_dbg;

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q[$];
    logic [7:0] last_r;
    logic       last_c, last_dz;

    typedef struct {
        logic [1:0] o;
        logic [7:0] a, b, r;
        logic       c, dz;
        int         lat;
    } vec_t;

    always #5 clk = ~clk;

    stack_arith_unit #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .in1(in1), .in2(in2),
        .result(result), .carryOut(carryOut), .div_zero(div_zero), .busy(busy),
        .done(done), .state_dbg(state_dbg)
    );

    function automatic logic [9:0] model(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
        int sa, sb, v;
        logic c, dz;
        logic [7:0] r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        c  = 1'b0;
        dz = 1'b0;
        v  = 0;
        case (o)
            2'd0: begin v = int'(a) + int'(b); c = (v > 255); end
            2'd1: begin v = int'(a) - int'(b); c = (v < 0); end
            2'd2: begin v = sa * sb; c = (v < -128) || (v > 127); end
            default: begin
                if (b == 8'd0) dz = 1'b1;
                else begin v = sa / sb; c = (v > 127); end
            end
        endcase
        r = v[7:0];
        return {dz, c, r};
    endfunction

    function automatic int model_lat(input logic [1:0] o, input logic [7:0] b);
        return (o == 2'd2 || (o == 2'd3 && b != 8'd0)) ? 9 : 1;
    endfunction

    // Issues one operation, scrambles the inputs after capture, and waits (bounded) for done.
    task automatic run_op(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] r, output logic c, output logic dz,
                          output int lat, output int busy_n, output logic busy_done,
                          output bit held, output bit to);
        @(negedge clk);
        start = 1'b1; op = o; in1 = a; in2 = b;
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom); in1 = 8'($urandom); in2 = 8'($urandom);
        lat = 0; busy_n = 0; held = 1'b1; to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (busy === 1'b1) busy_n++;
            if (result !== last_r || carryOut !== last_c || div_zero !== last_dz) held = 1'b0;
            @(posedge clk); #1;
            lat++;
            if (done === 1'b1) begin to = 1'b0; break; end
        end
        r = result; c = carryOut; dz = div_zero; busy_done = busy;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; op = 2'd0; in1 = 8'd5; in2 = 8'd6;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (result !== 8'd0 || carryOut !== 1'b0 || div_zero !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset outputs: got r=%h c=%b dz=%b busy=%b done=%b, want all 0", result, carryOut, div_zero, busy, done);
        end
        checks++;
        if (state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL reset state: got %0d, want 0 (IDLE)", state_dbg);
        end
        reset = 1'b0; start = 1'b0;
        last_r = 8'd0; last_c = 1'b0; last_dz = 1'b0;
    endtask

    task automatic test_add();
        vec_t v[$];
        logic [7:0] r; logic c, dz, bd; int lat, bn; bit held, to;
        v.push_back('{2'd0, 8'd2,   8'd7,   8'd9,   1'b0, 1'b0, 1});
        v.push_back('{2'd0, 8'd3,   8'hFC,  8'hFF,  1'b0, 1'b0, 1});
        v.push_back('{2'd0, 8'hFF,  8'h01,  8'h00,  1'b1, 1'b0, 1});
        foreach (v[i]) begin
            run_op(v[i].o, v[i].a, v[i].b, r, c, dz, lat, bn, bd, held, to);
            checks++;
            if (to || r !== v[i].r || c !== v[i].c || dz !== v[i].dz) begin
                errors++;
                $display("FAIL add[%0d] value: got r=%h c=%b dz=%b, want r=%h c=%b dz=%b", i, r, c, dz, v[i].r, v[i].c, v[i].dz);
            end
            checks++;
            if (lat != v[i].lat || bn != v[i].lat || bd !== 1'b0 || !held) begin
                errors++;
                $display("FAIL add[%0d] timing: got lat=%0d busy_cycles=%0d busy_at_done=%b held=%0d, want %0d %0d 0 1", i, lat, bn, bd, held, v[i].lat, v[i].lat);
            end
            last_r = v[i].r; last_c = v[i].c; last_dz = v[i].dz;
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || result !== 8'h00 || carryOut !== 1'b1) begin
            errors++;
            $display("FAIL add done_pulse: got done=%b r=%h c=%b, want done=0 r=00 c=1", done, result, carryOut);
        end
    endtask

    task automatic test_sub();
        vec_t v[$];
        logic [7:0] r; logic c, dz, bd; int lat, bn; bit held, to;
        v.push_back('{2'd1, 8'd8, 8'd2, 8'd6,   1'b0, 1'b0, 1});
        v.push_back('{2'd1, 8'd4, 8'd6, 8'hFE,  1'b1, 1'b0, 1});
        foreach (v[i]) begin
            run_op(v[i].o, v[i].a, v[i].b, r, c, dz, lat, bn, bd, held, to);
            checks++;
            if (to || r !== v[i].r || c !== v[i].c || dz !== v[i].dz || lat != v[i].lat || bn != v[i].lat || !held) begin
                errors++;
                $display("FAIL sub[%0d]: got r=%h c=%b dz=%b lat=%0d busy=%0d held=%0d, want r=%h c=%b dz=%b lat=%0d", i, r, c, dz, lat, bn, held, v[i].r, v[i].c, v[i].dz, v[i].lat);
            end
            last_r = v[i].r; last_c = v[i].c; last_dz = v[i].dz;
        end
    endtask

    task automatic test_mul();
        vec_t v[$];
        logic [7:0] r; logic c, dz, bd; int lat, bn; bit held, to;
        v.push_back('{2'd2, 8'd3,  8'd9,  8'h1B, 1'b0, 1'b0, 9});
        v.push_back('{2'd2, 8'd3,  8'hFA, 8'hEE, 1'b0, 1'b0, 9});
        v.push_back('{2'd2, 8'd16, 8'd16, 8'h00, 1'b1, 1'b0, 9});
        foreach (v[i]) begin
            run_op(v[i].o, v[i].a, v[i].b, r, c, dz, lat, bn, bd, held, to);
            checks++;
            if (to || r !== v[i].r || c !== v[i].c || dz !== v[i].dz || lat != v[i].lat || bn != v[i].lat || bd !== 1'b0 || !held) begin
                errors++;
                $display("FAIL mul[%0d]: got r=%h c=%b dz=%b lat=%0d busy=%0d held=%0d, want r=%h c=%b dz=%b lat=%0d", i, r, c, dz, lat, bn, held, v[i].r, v[i].c, v[i].dz, v[i].lat);
            end
            last_r = v[i].r; last_c = v[i].c; last_dz = v[i].dz;
        end
    endtask

    task automatic test_div();
        vec_t v[$];
        logic [7:0] r; logic c, dz, bd; int lat, bn; bit held, to;
        v.push_back('{2'd3, 8'h36, 8'd27,  8'd2,  1'b0, 1'b0, 9});
        v.push_back('{2'd3, 8'd2,  8'hFE,  8'hFF, 1'b0, 1'b0, 9});
        v.push_back('{2'd3, 8'd7,  8'hFE,  8'hFD, 1'b0, 1'b0, 9});
        v.push_back('{2'd3, 8'h80, 8'hFF,  8'h80, 1'b1, 1'b0, 9});
        v.push_back('{2'd3, 8'd5,  8'h00,  8'h00, 1'b0, 1'b1, 1});
        v.push_back('{2'd0, 8'd1,  8'd1,   8'd2,  1'b0, 1'b0, 1});
        foreach (v[i]) begin
            run_op(v[i].o, v[i].a, v[i].b, r, c, dz, lat, bn, bd, held, to);
            checks++;
            if (to || r !== v[i].r || c !== v[i].c || dz !== v[i].dz || lat != v[i].lat || bn != v[i].lat || !held) begin
                errors++;
                $display("FAIL div[%0d]: got r=%h c=%b dz=%b lat=%0d busy=%0d held=%0d, want r=%h c=%b dz=%b lat=%0d", i, r, c, dz, lat, bn, held, v[i].r, v[i].c, v[i].dz, v[i].lat);
            end
            last_r = v[i].r; last_c = v[i].c; last_dz = v[i].dz;
        end
    endtask

    task automatic test_abort();
        bit saw_done;
        @(negedge clk);
        start = 1'b1; op = 2'd2; in1 = 8'd3; in2 = 8'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || result !== 8'd0 || done !== 1'b0 || state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL abort outputs: got busy=%b r=%h done=%b state=%0d, want 0 00 0 0", busy, result, done, state_dbg);
        end
        reset = 1'b0;
        saw_done = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL abort no_done: got a done pulse, want none");
        end
        last_r = 8'd0; last_c = 1'b0; last_dz = 1'b0;
    endtask

    task automatic test_ignore_start();
        int cycles, ndone, first_lat;
        logic [7:0] first_r;
        @(negedge clk);
        start = 1'b1; op = 2'd2; in1 = 8'd3; in2 = 8'd9;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; op = 2'd1; in1 = 8'd8; in2 = 8'd2;
        @(posedge clk); #1;
        start = 1'b0;
        cycles = 2; ndone = 0; first_lat = 0; first_r = 8'hXX;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            cycles++;
            if (done === 1'b1) begin
                ndone++;
                if (ndone == 1) begin first_lat = cycles; first_r = result; end
            end
        end
        checks++;
        if (ndone != 1 || first_lat != 9 || first_r !== 8'd27) begin
            errors++;
            $display("FAIL ignore_start: got dones=%0d lat=%0d r=%h, want dones=1 lat=9 r=1b", ndone, first_lat, first_r);
        end
        last_r = 8'd27; last_c = 1'b0; last_dz = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit got;
        @(negedge clk);
        start = 1'b1; op = 2'd0; in1 = 8'd2; in2 = 8'd7;
        @(posedge clk); #1;
        start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin got = 1'b1; break; end
        end
        checks++;
        if (!got || result !== 8'd9) begin
            errors++;
            $display("FAIL b2b first: got done_seen=%0d r=%h, want 1 09", got, result);
        end
        start = 1'b1; op = 2'd1; in1 = 8'd8; in2 = 8'd2;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b gap: got done=%b busy=%b, want done=0 busy=1", done, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || result !== 8'd6 || carryOut !== 1'b0) begin
            errors++;
            $display("FAIL b2b second: got done=%b r=%h c=%b, want done=1 r=06 c=0", done, result, carryOut);
        end
        last_r = 8'd6; last_c = 1'b0; last_dz = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] corners[5] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
        logic [7:0] a, b, r; logic [1:0] o; logic c, dz, bd; logic [9:0] e;
        int lat, bn; bit held, to;
        for (int n = 0; n < 150; n++) begin
            o = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 8'($urandom);
            b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 8'($urandom);
            exp_q.push_back(model(o, a, b));
            run_op(o, a, b, r, c, dz, lat, bn, bd, held, to);
            e = exp_q.pop_front();
            checks++;
            if (to || {dz, c, r} !== e || lat != model_lat(o, b) || bn != lat || bd !== 1'b0 || !held) begin
                errors++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: got r=%h c=%b dz=%b lat=%0d busy=%0d held=%0d, want r=%h c=%b dz=%b lat=%0d",
                         n, o, a, b, r, c, dz, lat, bn, held, e[7:0], e[8], e[9], model_lat(o, b));
            end
            last_r = e[7:0]; last_c = e[8]; last_dz = e[9];
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'd0; in1 = 8'd0; in2 = 8'd0;
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_div();
        test_abort();
        test_ignore_start();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
